// File: rtl/fifo_axis_pkg.sv
// Shared constants and types for the FIFO-to-AXI-Stream reader.
package fifo_axis_pkg;

    localparam int unsigned BUF_DEPTH = 2;

    typedef logic [1:0] occ_t;

    // Beat counter must represent 0..packet_len-1 with one bit of headroom
    function automatic int unsigned beat_cnt_width(input int unsigned packet_len);
        return $clog2(packet_len) + 1;
    endfunction

endpackage

// File: rtl/axis_out_buf.sv
// Two-entry in-order skid buffer between FIFO read data and the stream output.
module axis_out_buf
    import fifo_axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_a_rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output occ_t                  occ
);

    logic [DATA_WIDTH-1:0] ent0;
    logic [DATA_WIDTH-1:0] ent1;

    assign head_data = ent0;

    // ent0 is always the head; simultaneous push/pop keeps order by shifting first
    always_ff @(posedge i_clk or posedge i_a_rst) begin
        if (i_a_rst) begin
            ent0 <= '0;
            ent1 <= '0;
            occ  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == occ_t'(0)) begin
                        ent0 <= push_data;
                    end else begin
                        ent1 <= push_data;
                    end
                    occ <= occ + occ_t'(1);
                end
                2'b01: begin
                    ent0 <= ent1;
                    occ  <= occ - occ_t'(1);
                end
                2'b11: begin
                    if (occ == occ_t'(BUF_DEPTH)) begin
                        ent0 <= ent1;
                        ent1 <= push_data;
                    end else begin
                        ent0 <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_axis_reader.sv
// Reads a 1-cycle-latency FIFO and presents the words as an AXI-Stream master.
// Define FIFO_AXIS_READER_TLAST_EN to generate tlast every PACKET_LEN beats.
module fifo_axis_reader
    import fifo_axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PACKET_LEN = 16
) (
    input  logic                  i_clk,
    input  logic                  i_a_rst,
    input  logic                  i_enable,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
    input  logic                  i_fifo_rd_valid,
    output logic [DATA_WIDTH-1:0] o_m_axis_tdata,
    output logic                  o_m_axis_tvalid,
    input  logic                  i_m_axis_tready,
    output logic                  o_m_axis_tlast,
    output logic                  o_seq_err
);

    if (PACKET_LEN < 1) begin : g_bad_packet_len
        $error("fifo_axis_reader: PACKET_LEN must be >= 1");
    end

    occ_t       occ;
    logic       infl;
    logic       pop;
    logic       push;
    logic       stray_valid;
    logic       overflow;
    logic [2:0] pending;

    assign pop             = o_m_axis_tvalid & i_m_axis_tready;
    assign o_m_axis_tvalid = (occ != occ_t'(0));

    // Reserve a buffer slot for every read before it is issued
    assign pending      = 3'(occ) + 3'(infl) - 3'(pop);
    assign o_fifo_rd_en = ~i_a_rst & i_enable & ~i_fifo_empty & (pending < 3'(BUF_DEPTH));

    assign stray_valid = i_fifo_rd_valid & ~infl;
    assign overflow    = i_fifo_rd_valid & infl & (occ == occ_t'(BUF_DEPTH)) & ~pop;
    assign push        = i_fifo_rd_valid & infl & ~overflow;

    axis_out_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .i_clk     (i_clk),
        .i_a_rst   (i_a_rst),
        .push      (push),
        .push_data (i_fifo_rd_data),
        .pop       (pop),
        .head_data (o_m_axis_tdata),
        .occ       (occ)
    );

    // Latency is exactly one cycle, so the in-flight flag mirrors last cycle's request
    always_ff @(posedge i_clk or posedge i_a_rst) begin
        if (i_a_rst) begin
            infl      <= 1'b0;
            o_seq_err <= 1'b0;
        end else begin
            infl      <= o_fifo_rd_en;
            o_seq_err <= o_seq_err | stray_valid | overflow;
        end
    end

`ifdef FIFO_AXIS_READER_TLAST_EN
    localparam int unsigned BEAT_W = beat_cnt_width(PACKET_LEN);

    logic [BEAT_W-1:0] beat_cnt;

    always_ff @(posedge i_clk or posedge i_a_rst) begin
        if (i_a_rst) begin
            beat_cnt <= '0;
        end else if (pop) begin
            if (beat_cnt == BEAT_W'(PACKET_LEN - 1)) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + BEAT_W'(1);
            end
        end
    end

    assign o_m_axis_tlast = o_m_axis_tvalid & (beat_cnt == BEAT_W'(PACKET_LEN - 1));
`else
    assign o_m_axis_tlast = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Scoreboard bench for fifo_axis_reader with a 1-cycle-latency FIFO model.
module tb_fifo_axis_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned PL = 4;

    logic          i_clk = 1'b0;
    logic          i_a_rst;
    logic          i_enable;
    logic          i_fifo_empty;
    logic          o_fifo_rd_en;
    logic [DW-1:0] i_fifo_rd_data;
    logic          i_fifo_rd_valid;
    logic [DW-1:0] o_m_axis_tdata;
    logic          o_m_axis_tvalid;
    logic          i_m_axis_tready;
    logic          o_m_axis_tlast;
    logic          o_seq_err;

    fifo_axis_reader #(
        .DATA_WIDTH(DW),
        .PACKET_LEN(PL)
    ) dut (
        .i_clk          (i_clk),
        .i_a_rst        (i_a_rst),
        .i_enable       (i_enable),
        .i_fifo_empty   (i_fifo_empty),
        .o_fifo_rd_en   (o_fifo_rd_en),
        .i_fifo_rd_data (i_fifo_rd_data),
        .i_fifo_rd_valid(i_fifo_rd_valid),
        .o_m_axis_tdata (o_m_axis_tdata),
        .o_m_axis_tvalid(o_m_axis_tvalid),
        .i_m_axis_tready(i_m_axis_tready),
        .o_m_axis_tlast (o_m_axis_tlast),
        .o_seq_err      (o_seq_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // FIFO model: fixed memory, stimulus advances wr_ptr, model advances rd_ptr
    logic [DW-1:0] fifo_mem [256];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic          mdl_valid;
    logic [DW-1:0] mdl_data;
    logic          force_valid;

    assign i_fifo_empty    = (rd_ptr == wr_ptr);
    assign i_fifo_rd_valid = mdl_valid | force_valid;
    assign i_fifo_rd_data  = mdl_data;

    always @(posedge i_clk or posedge i_a_rst) begin
        if (i_a_rst) begin
            mdl_valid <= 1'b0;
            mdl_data  <= '0;
            rd_ptr    <= wr_ptr;
        end else begin
            mdl_valid <= o_fifo_rd_en;
            if (o_fifo_rd_en) begin
                mdl_data <= fifo_mem[rd_ptr % 256];
                rd_ptr   <= rd_ptr + 1;
            end
        end
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor state
    int            rd_en_cnt      = 0;
    int            acc_cnt        = 0;
    int            first_rd_cyc   = -1;
    int            first_beat_cyc = -1;
    int            last_beat_cyc  = -1;
    logic          prev_stall     = 1'b0;
    logic [DW-1:0] prev_data      = '0;
    logic          prev_last      = 1'b0;

    always @(negedge i_clk) begin
        if (!i_a_rst) begin
            check("rd_en_while_empty", 32'(o_fifo_rd_en & i_fifo_empty), 32'd0);
            check("occ_le_2", 32'(dut.occ <= 2'd2), 32'd1);
            if (o_fifo_rd_en) begin
                rd_en_cnt++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            if (prev_stall) begin
                check("stall_tvalid", 32'(o_m_axis_tvalid), 32'd1);
                check("stall_tdata", 32'(o_m_axis_tdata), 32'(prev_data));
                check("stall_tlast", 32'(o_m_axis_tlast), 32'(prev_last));
            end
            if (o_m_axis_tvalid && i_m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=0x%0h required=no_beat", o_m_axis_tdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("beat_tdata", 32'(o_m_axis_tdata), 32'(e.data));
                    check("beat_tlast", 32'(o_m_axis_tlast), 32'(e.last));
                end
                acc_cnt++;
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
            end
            prev_stall = o_m_axis_tvalid & ~i_m_axis_tready;
            prev_data  = o_m_axis_tdata;
            prev_last  = o_m_axis_tlast;
        end else begin
            prev_stall = 1'b0;
        end
    end

    int tb_beat = 0;

    // Preload FIFO and push the matching expected beats
    task automatic load(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.data = base + DW'(i);
`ifdef FIFO_AXIS_READER_TLAST_EN
            e.last = (tb_beat == PL - 1);
`else
            e.last = 1'b0;
`endif
            tb_beat = (tb_beat + 1) % PL;
            exp_q.push_back(e);
            fifo_mem[wr_ptr % 256] = e.data;
            wr_ptr++;
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Run until every expected beat is consumed; pattern=1 uses tready 1,0,0,1
    task automatic drain(input bit pattern, input int max_cycles);
        int i = 0;
        while (exp_q.size() != 0 && i < max_cycles) begin
            if (pattern) i_m_axis_tready = (i % 4 == 0) || (i % 4 == 3);
            else         i_m_axis_tready = 1'b1;
            step();
            i++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_left required=0_left", exp_q.size());
        end
        i_m_axis_tready = 1'b1;
        repeat (4) step();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tvalid"}, 32'(o_m_axis_tvalid), 32'd0);
        check({tag, "_tlast"}, 32'(o_m_axis_tlast), 32'd0);
        check({tag, "_tdata"}, 32'(o_m_axis_tdata), 32'd0);
        check({tag, "_seq_err"}, 32'(o_seq_err), 32'd0);
        check({tag, "_rd_en"}, 32'(o_fifo_rd_en), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_a_rst         = 1'b1;
        i_enable        = 1'b0;
        i_m_axis_tready = 1'b0;
        force_valid     = 1'b0;
        repeat (2) step();
        fifo_mem[0] = 8'hAA;
        wr_ptr      = 1;
        i_enable    = 1'b1;
        #1;
        check_outputs_zero("reset");
        step();
        wr_ptr   = 0;
        i_enable = 1'b0;
        step();
        i_a_rst = 1'b0;
        step();

        // Back-to-back stream of 8 words, two packets
        first_rd_cyc   = -1;
        first_beat_cyc = -1;
        i_m_axis_tready = 1'b1;
        load(8, 8'h01);
        i_enable = 1'b1;
        drain(1'b0, 100);
        check("first_beat_latency", 32'(first_beat_cyc - first_rd_cyc), 32'd2);
        check("burst_span", 32'(last_beat_cyc - first_beat_cyc), 32'd7);
        check("no_err_burst", 32'(o_seq_err), 32'd0);

        // Backpressure pattern
        load(6, 8'h01);
        drain(1'b1, 200);
        check("no_err_stall", 32'(o_seq_err), 32'd0);

        // Single word
        rd_en_cnt = 0;
        acc_cnt   = 0;
        load(1, 8'h55);
        drain(1'b0, 50);
        check("single_rd_en", 32'(rd_en_cnt), 32'd1);
        check("single_beat", 32'(acc_cnt), 32'd1);
        check("no_err_single", 32'(o_seq_err), 32'd0);

        // Unsolicited read-valid
        force_valid = 1'b1;
        step();
        force_valid = 1'b0;
        check("seq_err_set", 32'(o_seq_err), 32'd1);
        check("stray_dropped", 32'(o_m_axis_tvalid), 32'd0);
        repeat (5) step();
        check("seq_err_sticky", 32'(o_seq_err), 32'd1);
        i_a_rst = 1'b1;
        #1;
        check("seq_err_cleared", 32'(o_seq_err), 32'd0);
        exp_q.delete();
        tb_beat = 0;
        step();
        i_a_rst = 1'b0;
        step();

        // Reset mid-packet after two beats
        acc_cnt = 0;
        load(8, 8'h21);
        for (int i = 0; i < 50 && acc_cnt < 2; i++) step();
        check("two_beats_seen", 32'(acc_cnt), 32'd2);
        i_a_rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        exp_q.delete();
        tb_beat = 0;
        step();
        i_a_rst = 1'b0;
        step();
        load(4, 8'h11);
        drain(1'b0, 50);
        check("no_err_after_rst", 32'(o_seq_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_axis_reader.md
FIFO_AXIS_READER -- requirements
Module: fifo_axis_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the FIFO word and stream data width.
REQ-002 SHALL have parameter PACKET_LEN, default 16, the beats per packet (legal range >= 1).
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port i_a_rst, input, 1, the reset; it is asynchronous and active-high.
REQ-005 SHALL have port i_enable, input, 1; while 1, new FIFO reads are permitted.
REQ-006 SHALL have port i_fifo_empty, input, 1, the FIFO empty flag.
REQ-007 SHALL have port o_fifo_rd_en, output, 1, the FIFO read request.
REQ-008 SHALL have port i_fifo_rd_data, input, DATA_WIDTH, the FIFO read data.
REQ-009 SHALL have port i_fifo_rd_valid, input, 1, the FIFO read-data-valid strobe.
REQ-010 SHALL have port o_m_axis_tdata, output, DATA_WIDTH, the stream data.
REQ-011 SHALL have port o_m_axis_tvalid, output, 1, the stream valid.
REQ-012 SHALL have port i_m_axis_tready, input, 1, the stream ready.
REQ-013 SHALL have port o_m_axis_tlast, output, 1, the stream end-of-packet.
REQ-014 SHALL have port o_seq_err, output, 1, a sticky protocol-error flag.

Function
REQ-015 SHALL treat FIFO read latency as exactly 1 cycle: data and i_fifo_rd_valid arrive the cycle after o_fifo_rd_en.
REQ-016 SHALL hold returned words in a 2-entry output buffer; occ (0..2) is the count of valid entries and infl (0..1) the count of reads in flight.
REQ-017 SHALL assert o_fifo_rd_en combinationally iff i_enable=1, i_fifo_empty=0, and (occ + infl - pop) < 2, where pop = tvalid & tready.
REQ-018 SHALL never assert o_fifo_rd_en while i_fifo_empty=1.
REQ-019 SHALL sustain 1 beat/cycle when the FIFO is non-empty and tready stays 1.
REQ-020 SHALL drive o_m_axis_tvalid = (occ != 0) and o_m_axis_tdata = head entry, and preserve FIFO order.
REQ-021 SHALL keep tdata/tlast stable while tvalid=1 and tready=0.
REQ-022 SHALL, on the same cycle as a push (rd_valid) and a pop, leave occ unchanged and place the new word behind the remaining entry.
REQ-023 SHALL set o_seq_err if i_fifo_rd_valid=1 while infl=0, or if a push arrives with occ=2 and no pop; the offending word is dropped.
REQ-024 SHALL, once o_seq_err is set, hold it at 1 until reset.
REQ-025 SHALL, when i_enable falls, issue no new reads, still capture an in-flight word, and keep draining the buffer.
REQ-026 SHALL count accepted beats in beat_cnt (width $clog2(PACKET_LEN)+1) and wrap it to 0 on the handshake of the beat at PACKET_LEN-1.

Reset
REQ-027 SHALL, while i_a_rst=1, force occ=0, infl=0, beat_cnt=0, o_m_axis_tvalid=0, o_m_axis_tlast=0, o_m_axis_tdata=0, o_seq_err=0, o_fifo_rd_en=0.
REQ-028 SHALL discard buffered and in-flight data on reset asserted mid-operation; the FIFO shares this reset domain, and reset deassertion is synchronous to i_clk.

Configuration
REQ-029 SHALL, with macro FIFO_AXIS_READER_TLAST_EN defined, drive o_m_axis_tlast = tvalid & (beat_cnt == PACKET_LEN-1).
REQ-030 SHALL, with FIFO_AXIS_READER_TLAST_EN undefined, tie o_m_axis_tlast to 0 and not implement beat_cnt.

Structure
REQ-031 SHALL place BUF_DEPTH=2, the occupancy typedef (2 bits) and the beat-counter width function in package fifo_axis_pkg.
REQ-032 SHALL implement the 2-entry buffer as sub-module axis_out_buf (push/pop/data/occ); read issue, infl, beat_cnt and error logic stay in the top.

Verification (DATA_WIDTH=8, PACKET_LEN=4, TLAST_EN defined unless noted)
REQ-033 SHALL cover: FIFO preloaded 0x01..0x08, tready=1 -> 8 beats on consecutive cycles, first beat 2 cycles after rd_en, tlast on 0x04 and 0x08.
REQ-034 SHALL cover: 6 words preloaded, tready pattern 1,0,0,1 repeating -> tdata stable during stalls, order 0x01..0x06 intact, rd_en never with empty=1, occ never >2.
REQ-035 SHALL cover: FIFO holds 1 word, tready=1 -> exactly one rd_en pulse, one beat, no error.
REQ-036 SHALL cover: forced rd_valid with no request -> o_seq_err=1 next cycle and held until i_a_rst pulse.
REQ-037 SHALL cover: reset asserted mid-packet after beat 2 -> outputs 0 immediately; after release, the next beat has beat_cnt=0 (tlast on 4th beat).
REQ-038 SHALL cover: TLAST_EN undefined, 8 words -> o_m_axis_tlast constant 0, data identical to REQ-033.
